// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared constants and helpers for the tail of the 512-point, 16-lane FFT
// pipeline.
//   NUM_POINTS : FFT size (power of two)
//   LANES      : samples carried per beat
//   BEATS      : beats per frame (NUM_POINTS / LANES)
//   ABITS      : bank address width (log2 NUM_POINTS)
//   bank_st_e  : life cycle of one ping-pong storage bank
//   bitrev     : reverses the low nbits of an index
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int NUM_POINTS = 512;
    localparam int LANES      = 16;
    localparam int BEATS      = NUM_POINTS / LANES;
    localparam int ABITS      = $clog2(NUM_POINTS);

    // A bank is filled by the write side, handed over once complete, and
    // drained by the read side before it can be refilled.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_e;

    // Shift the low nbits of idx out LSB-first and into the result
    // LSB-first, which mirrors their order. Bits above nbits come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] r;
        logic [31:0] x;
        r = '0;
        x = idx;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r = {r[30:0], x[0]};
                x = x >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// ----------------------------------------------------------------------------
// fft_reorder_bank
// One storage bank of the output reorder buffer: a flop array holding one
// full frame of complex samples. The array is deliberately not reset.
//   clk              : rising-edge clock
//   we_i             : write strobe for one 16-lane beat
//   wrow_i           : beat index of the incoming (bit-reversed) beat
//   wre_i / wim_i    : incoming lane samples
//   rrow_i           : natural-order row to present on the read port
//   rre_o / rim_o    : combinational read data of row rrow_i
// ----------------------------------------------------------------------------
module fft_reorder_bank #(
    parameter int WIDTH      = 15,
    parameter int NUM_POINTS = 512,
    parameter int LANES      = 16
) (
    input  logic                            clk,
    input  logic                            we_i,
    input  logic [$clog2(NUM_POINTS/LANES)-1:0] wrow_i,
    input  logic [WIDTH-1:0]                wre_i [0:LANES-1],
    input  logic [WIDTH-1:0]                wim_i [0:LANES-1],
    input  logic [$clog2(NUM_POINTS/LANES)-1:0] rrow_i,
    output logic [WIDTH-1:0]                rre_o [0:LANES-1],
    output logic [WIDTH-1:0]                rim_o [0:LANES-1]
);
    import fft_pkg::*;

    localparam int AW = $clog2(NUM_POINTS);

    logic [WIDTH-1:0] mem_re [NUM_POINTS];
    logic [WIDTH-1:0] mem_im [NUM_POINTS];

    logic [AW-1:0] waddr [LANES];
    logic [AW-1:0] raddr [LANES];

    // Lane l of write beat b is stream position b*LANES+l; it lands at the
    // bit-reversed address so the bank ends up holding natural order.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            waddr[l] = AW'(bitrev(32'(wrow_i) * 32'(LANES) + 32'(l), AW));
        end
    end

    // Read row k is simply LANES consecutive natural-order entries.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            raddr[l] = AW'(32'(rrow_i) * 32'(LANES) + 32'(l));
            rre_o[l] = mem_re[raddr[l]];
            rim_o[l] = mem_im[raddr[l]];
        end
    end

    // Scatter write: all lanes of a beat hit distinct addresses.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                mem_re[waddr[l]] <= wre_i[l];
                mem_im[waddr[l]] <= wim_i[l];
            end
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// ----------------------------------------------------------------------------
// fft_out_reorder
// Output reorder buffer at the end of the FFT pipeline. Bit-reversed input
// frames are written into one half of a ping-pong bank pair and read back in
// natural order over a valid/ready handshake. Frames arriving while no bank
// is free are dropped and flagged.
//   clk, rstn           : clock, asynchronous active-low reset
//   din_re/din_im       : bit-reversed input lanes
//   din_valid           : input beat qualifier (no input backpressure)
//   dout_re/dout_im     : registered natural-order output lanes
//   dout_valid          : output beat present
//   dout_ready          : consumer accepts the beat
//   dout_last           : last beat of a frame (qualified by dout_valid)
//   overflow            : sticky, a frame was dropped
// ----------------------------------------------------------------------------
module fft_out_reorder #(
    parameter int WIDTH      = 15,
    parameter int NUM_POINTS = fft_pkg::NUM_POINTS,
    parameter int LANES      = fft_pkg::LANES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din_re [0:LANES-1],
    input  logic [WIDTH-1:0] din_im [0:LANES-1],
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout_re [0:LANES-1],
    output logic [WIDTH-1:0] dout_im [0:LANES-1],
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             overflow
);
    import fft_pkg::*;

    localparam int FRAME_BEATS = NUM_POINTS / LANES;
    localparam int CBITS       = $clog2(FRAME_BEATS);
    localparam logic [CBITS-1:0] LAST_BEAT = CBITS'(FRAME_BEATS - 1);

    bank_st_e         bank_q [2];
    bank_st_e         bank_d [2];
    logic [CBITS-1:0] wcnt_q, wcnt_d;
    logic [CBITS-1:0] rcnt_q, rcnt_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic             drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] dout_re_q [0:LANES-1];
    logic [WIDTH-1:0] dout_im_q [0:LANES-1];
    logic             dout_valid_q;
    logic             dout_last_q;

    logic             hs, last_hs, out_take;
    logic             rb_next, load_cont, load_start, load, rd_sel;
    logic [CBITS-1:0] rd_row;
    logic             beat0, beat_end, admit, wr_en;
    logic             we0, we1;

    logic [WIDTH-1:0] b0_re [0:LANES-1];
    logic [WIDTH-1:0] b0_im [0:LANES-1];
    logic [WIDTH-1:0] b1_re [0:LANES-1];
    logic [WIDTH-1:0] b1_im [0:LANES-1];

    // Read side. rcnt_q is the next row to load; entering DRAINING always
    // loads row 0 and leaves rcnt_q at 1, so a DRAINING bank with rcnt_q
    // back at 0 has every row in flight and only awaits its last handshake.
    // On that handshake the other bank may start in the same cycle, which
    // keeps back-to-back frames gapless.
    assign hs         = dout_valid_q & dout_ready;
    assign last_hs    = hs & dout_last_q;
    assign out_take   = ~dout_valid_q | dout_ready;
    assign rb_next    = last_hs ? ~rbank_q : rbank_q;
    assign load_cont  = out_take && (bank_q[rbank_q] == DRAINING) && (rcnt_q != '0);
    assign load_start = out_take && !load_cont && (bank_q[rb_next] == FULL);
    assign load       = load_cont | load_start;
    assign rd_sel     = load_start ? rb_next : rbank_q;
    assign rd_row     = load_start ? '0 : rcnt_q;

    // Write side. A bank still draining its final beat counts as free when
    // that beat handshakes in the same cycle as the new frame's beat 0.
    assign beat0    = (wcnt_q == '0);
    assign beat_end = (wcnt_q == LAST_BEAT);
    assign admit    = (bank_q[wbank_q] == EMPTY) ||
                      ((bank_q[wbank_q] == DRAINING) && last_hs && (rbank_q == wbank_q));
    assign wr_en    = din_valid && (beat0 ? admit : !drop_q);
    assign we0      = wr_en && !wbank_q;
    assign we1      = wr_en &&  wbank_q;

    fft_reorder_bank #(
        .WIDTH(WIDTH), .NUM_POINTS(NUM_POINTS), .LANES(LANES)
    ) u_bank0 (
        .clk(clk), .we_i(we0), .wrow_i(wcnt_q), .wre_i(din_re), .wim_i(din_im),
        .rrow_i(rd_row), .rre_o(b0_re), .rim_o(b0_im)
    );

    fft_reorder_bank #(
        .WIDTH(WIDTH), .NUM_POINTS(NUM_POINTS), .LANES(LANES)
    ) u_bank1 (
        .clk(clk), .we_i(we1), .wrow_i(wcnt_q), .wre_i(din_re), .wim_i(din_im),
        .rrow_i(rd_row), .rre_o(b1_re), .rim_o(b1_im)
    );

    // Next-state for counters, pointers and both bank state machines. The
    // write-side updates come last so that a bank freed and re-admitted in
    // the same cycle ends up FILLING.
    always_comb begin
        bank_d  = bank_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wbank_d = wbank_q;
        rbank_d = rb_next;
        drop_d  = drop_q;
        ovf_d   = ovf_q;

        if (load_start) begin
            rcnt_d = CBITS'(1);
        end else if (load_cont) begin
            rcnt_d = (rcnt_q == LAST_BEAT) ? '0 : rcnt_q + CBITS'(1);
        end

        if (last_hs) begin
            bank_d[rbank_q] = EMPTY;
        end
        if (load_start) begin
            bank_d[rb_next] = DRAINING;
        end

        if (din_valid) begin
            wcnt_d = beat_end ? '0 : wcnt_q + CBITS'(1);
            if (beat0) begin
                drop_d = !admit;
                if (admit) begin
                    bank_d[wbank_q] = FILLING;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (beat_end && !drop_q) begin
                bank_d[wbank_q] = FULL;
                wbank_d         = ~wbank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output register: loads a new row whenever one is available and the
    // register is empty or being emptied; otherwise it holds its data and
    // just drops valid once the held beat is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < LANES; l++) begin
                dout_re_q[l] <= '0;
                dout_im_q[l] <= '0;
            end
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else if (load) begin
            for (int l = 0; l < LANES; l++) begin
                dout_re_q[l] <= rd_sel ? b1_re[l] : b0_re[l];
                dout_im_q[l] <= rd_sel ? b1_im[l] : b0_im[l];
            end
            dout_valid_q <= 1'b1;
            dout_last_q  <= (rd_row == LAST_BEAT);
        end else if (hs) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end
    end

    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign overflow   = ovf_q;

endmodule
